// File: rtl/lc4_regfile_mp.sv
// Multi-pipe LC4 register file with same-cycle write-to-read bypass and a
// per-register pending-writer scoreboard. Youngest (highest-index) pipe wins.
module lc4_regfile_mp #(
  parameter int n        = 16,
  parameter int LOG_REGS = 3,
  parameter int NPIPES   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         gwe,
  input  logic [NPIPES*LOG_REGS-1:0]   i_rs,
  input  logic [NPIPES*LOG_REGS-1:0]   i_rt,
  output logic [NPIPES*n-1:0]          o_rs_data,
  output logic [NPIPES*n-1:0]          o_rt_data,
  output logic [NPIPES-1:0]            o_rs_busy,
  output logic [NPIPES-1:0]            o_rt_busy,
  input  logic [NPIPES*LOG_REGS-1:0]   i_rd,
  input  logic [NPIPES*n-1:0]          i_wdata,
  input  logic [NPIPES-1:0]            i_rd_we,
  input  logic [NPIPES*LOG_REGS-1:0]   i_alloc_rd,
  input  logic [NPIPES-1:0]            i_alloc_we,
  output logic [(1<<LOG_REGS)-1:0]     o_busy_vec
);

  localparam int R = 1 << LOG_REGS;

  logic [n-1:0] regs_r [R];
  logic [R-1:0] pend_r;

  logic         wr_act_s;
  logic [R-1:0] wr_hit_s;
  logic [R-1:0] alloc_hit_s;
  logic [n-1:0] wr_data_s [R];

  assign wr_act_s   = rst & gwe;
  assign o_busy_vec = pend_r;

  // Per-register write and allocation decode; later pipes overwrite earlier ones.
  always_comb begin
    for (int r = 0; r < R; r++) begin
      wr_hit_s[r]    = 1'b0;
      alloc_hit_s[r] = 1'b0;
      wr_data_s[r]   = {n{1'b0}};
      for (int p = 0; p < NPIPES; p++) begin
        if (i_rd_we[p] && (i_rd[p*LOG_REGS +: LOG_REGS] == LOG_REGS'(r))) begin
          wr_hit_s[r]  = 1'b1;
          wr_data_s[r] = i_wdata[p*n +: n];
        end else begin
          wr_hit_s[r]  = wr_hit_s[r];
        end
        if (i_alloc_we[p] && (i_alloc_rd[p*LOG_REGS +: LOG_REGS] == LOG_REGS'(r))) begin
          alloc_hit_s[r] = 1'b1;
        end else begin
          alloc_hit_s[r] = alloc_hit_s[r];
        end
      end
    end
  end

  // Read ports: a bypassed read also hides the pending bit it is about to clear.
  always_comb begin
    o_rs_data = {(NPIPES*n){1'b0}};
    o_rt_data = {(NPIPES*n){1'b0}};
    o_rs_busy = {NPIPES{1'b0}};
    o_rt_busy = {NPIPES{1'b0}};
    for (int p = 0; p < NPIPES; p++) begin
      if (wr_act_s && wr_hit_s[i_rs[p*LOG_REGS +: LOG_REGS]]) begin
        o_rs_data[p*n +: n] = wr_data_s[i_rs[p*LOG_REGS +: LOG_REGS]];
        o_rs_busy[p]        = 1'b0;
      end else begin
        o_rs_data[p*n +: n] = regs_r[i_rs[p*LOG_REGS +: LOG_REGS]];
        o_rs_busy[p]        = pend_r[i_rs[p*LOG_REGS +: LOG_REGS]];
      end
      if (wr_act_s && wr_hit_s[i_rt[p*LOG_REGS +: LOG_REGS]]) begin
        o_rt_data[p*n +: n] = wr_data_s[i_rt[p*LOG_REGS +: LOG_REGS]];
        o_rt_busy[p]        = 1'b0;
      end else begin
        o_rt_data[p*n +: n] = regs_r[i_rt[p*LOG_REGS +: LOG_REGS]];
        o_rt_busy[p]        = pend_r[i_rt[p*LOG_REGS +: LOG_REGS]];
      end
    end
  end

  // Register storage and scoreboard; allocation outranks writeback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < R; r++) begin
        regs_r[r] <= {n{1'b0}};
      end
      pend_r <= {R{1'b0}};
    end else if (gwe) begin
      for (int r = 0; r < R; r++) begin
        if (wr_hit_s[r]) begin
          regs_r[r] <= wr_data_s[r];
        end else begin
          regs_r[r] <= regs_r[r];
        end
        if (alloc_hit_s[r]) begin
          pend_r[r] <= 1'b1;
        end else if (wr_hit_s[r]) begin
          pend_r[r] <= 1'b0;
        end else begin
          pend_r[r] <= pend_r[r];
        end
      end
    end else begin
      pend_r <= pend_r;
    end
  end

endmodule
